// File: rtl/mem_wb_pkg.sv
// Shared encodings for the memory-access / writeback stage.
package mem_wb_pkg;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Writeback source select; the unlisted code 2'b11 also means ALU
    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10
    } wb_sel_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_e;

    // Access size for a funct3; unknown encodings fall back to a full word
    function automatic size_e access_size(input logic [2:0] funct3, input logic is_load);
        size_e sz;
        sz = SZ_WORD;
        if (is_load) begin
            if (funct3 == F3_LB || funct3 == F3_LBU) sz = SZ_BYTE;
            else if (funct3 == F3_LH || funct3 == F3_LHU) sz = SZ_HALF;
        end else begin
            if (funct3 == F3_SB) sz = SZ_BYTE;
            else if (funct3 == F3_SH) sz = SZ_HALF;
        end
        return sz;
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational byte-lane logic: store replication and strobes, misalignment
// detection, and load lane extraction with sign/zero extension.
module lsu_data_align
    import mem_wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        funct3,
    input  logic              is_load,
    input  logic [1:0]        addr_lo,
    input  logic [XLEN-1:0]   store_data,
    output logic [XLEN-1:0]   store_wdata,
    output logic [XLEN/8-1:0] store_wstrb,
    output logic              misaligned,
    input  logic [2:0]        load_funct3,
    input  logic [1:0]        load_addr_lo,
    input  logic [XLEN-1:0]   load_rdata,
    output logic [XLEN-1:0]   load_data
);

    localparam int STRB_W = XLEN / 8;

    size_e           sz;
    logic [XLEN-1:0] shifted;

    // Store side: replicate data over all lanes, strobe only the addressed ones
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        sz          = access_size(funct3, is_load);
        store_wdata = store_data;
        store_wstrb = '1;
        misaligned  = 1'b0;
        case (sz)
            SZ_BYTE: begin
                store_wdata = {STRB_W{store_data[7:0]}};
                store_wstrb = STRB_W'(1) << addr_lo;
            end
            SZ_HALF: begin
                store_wdata = {(STRB_W/2){store_data[15:0]}};
                store_wstrb = STRB_W'(3) << addr_lo;
                misaligned  = addr_lo[0];
            end
            default: begin
                misaligned  = (addr_lo != 2'b00);
            end
        endcase
    end

    // Load side: bring the addressed lane down to bit 0, then extend
    always_comb begin
        shifted = load_rdata >> {load_addr_lo, 3'b000};
        case (load_funct3)
            F3_LB:   load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_LBU:  load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_LH:   load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_LHU:  load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: load_data = load_rdata;
        endcase
    end

endmodule

// File: rtl/mem_writeback_cycle.sv
// Memory-access and writeback stage: runs load/store transactions on a
// req/ack bus and drives the register-file write port.
module mem_writeback_cycle
    import mem_wb_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int REGISTER_SIZE = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [XLEN-1:0]          alu_result,
    input  logic [XLEN-1:0]          pc_in,
    input  logic                     dm_read_enable,
    input  logic                     dm_write_enable,
    input  logic [XLEN-1:0]          dm_write_data,
    input  logic [2:0]               dm_load_type,
    input  logic                     rf_write_enable,
    input  logic [REGISTER_SIZE-1:0] rf_write_addr,
    input  logic [1:0]               rf_write_data_sel,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [XLEN-1:0]          mem_addr,
    output logic [XLEN-1:0]          mem_wdata,
    output logic [XLEN/8-1:0]        mem_wstrb,
    input  logic                     mem_ack,
    input  logic [XLEN-1:0]          mem_rdata,
    output logic                     rf_writeback_enable,
    output logic [REGISTER_SIZE-1:0] rf_writeback_addr,
    output logic [XLEN-1:0]          rf_writeback_data,
    output logic                     stall,
    output logic                     misaligned
);

    state_e state, state_next;

    // Read wins when both enables are set: the store half is dropped
    logic mem_op, is_store;
    assign mem_op   = dm_read_enable | dm_write_enable;
    assign is_store = dm_write_enable & ~dm_read_enable;

    logic                     mis_now;
    logic [XLEN-1:0]          align_wdata;
    logic [XLEN/8-1:0]        align_wstrb;
    logic [XLEN-1:0]          load_data;
    logic [XLEN-1:0]          direct_data;
    logic                     wb_en_now;

    // Transaction context held while the bus access is outstanding
    logic                     txn_load;
    logic [2:0]               txn_funct3;
    logic [1:0]               txn_addr_lo;
    logic                     txn_wen;
    logic [REGISTER_SIZE-1:0] txn_rd;
    logic [1:0]               txn_sel;
    logic [XLEN-1:0]          txn_alt_data;

    lsu_data_align #(.XLEN(XLEN)) u_align (
        .funct3       (dm_load_type),
        .is_load      (dm_read_enable),
        .addr_lo      (alu_result[1:0]),
        .store_data   (dm_write_data),
        .store_wdata  (align_wdata),
        .store_wstrb  (align_wstrb),
        .misaligned   (mis_now),
        .load_funct3  (txn_funct3),
        .load_addr_lo (txn_addr_lo),
        .load_rdata   (mem_rdata),
        .load_data    (load_data)
    );

    assign direct_data = (rf_write_data_sel == WB_PC4) ? pc_in + XLEN'(4) : alu_result;
    assign wb_en_now   = rf_write_enable && (rf_write_addr != '0);

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next state and stall. In WAIT the held instruction is the one in flight,
    // so in_valid is not re-sampled; dropping stall on ack lets the next one in.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && mem_op && !mis_now) begin
                    state_next = WAIT;
                    stall      = 1'b1;
                end
            end
            WAIT: begin
                stall = !mem_ack;
                if (mem_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus outputs, transaction context and writeback port
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_req             <= 1'b0;
            mem_we              <= 1'b0;
            mem_addr            <= '0;
            mem_wdata           <= '0;
            mem_wstrb           <= '0;
            rf_writeback_enable <= 1'b0;
            rf_writeback_addr   <= '0;
            rf_writeback_data   <= '0;
            misaligned          <= 1'b0;
            txn_load            <= 1'b0;
            txn_funct3          <= '0;
            txn_addr_lo         <= '0;
            txn_wen             <= 1'b0;
            txn_rd              <= '0;
            txn_sel             <= '0;
            txn_alt_data        <= '0;
        end else begin
            rf_writeback_enable <= 1'b0;
            misaligned          <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (!mem_op) begin
                            rf_writeback_enable <= wb_en_now;
                            rf_writeback_addr   <= rf_write_addr;
                            rf_writeback_data   <= direct_data;
                        end else if (mis_now) begin
                            misaligned <= 1'b1;
                        end else begin
                            mem_req      <= 1'b1;
                            mem_we       <= is_store;
                            mem_addr     <= alu_result & ~XLEN'(3);
                            mem_wdata    <= is_store ? align_wdata : '0;
                            mem_wstrb    <= is_store ? align_wstrb : '0;
                            txn_load     <= dm_read_enable;
                            txn_funct3   <= dm_load_type;
                            txn_addr_lo  <= alu_result[1:0];
                            txn_wen      <= wb_en_now;
                            txn_rd       <= rf_write_addr;
                            txn_sel      <= rf_write_data_sel;
                            txn_alt_data <= direct_data;
                        end
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (txn_load) begin
                            rf_writeback_enable <= txn_wen;
                            rf_writeback_addr   <= txn_rd;
                            rf_writeback_data   <= (txn_sel == WB_LOAD) ? load_data : txn_alt_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_writeback_cycle.sv
// Directed bench for mem_writeback_cycle with a writeback scoreboard.
module tb_mem_writeback_cycle;
    import mem_wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] alu_result, pc_in, dm_write_data, mem_rdata;
    logic        dm_read_enable, dm_write_enable, rf_write_enable;
    logic [2:0]  dm_load_type;
    logic [4:0]  rf_write_addr;
    logic [1:0]  rf_write_data_sel;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        rf_writeback_enable;
    logic [4:0]  rf_writeback_addr;
    logic [31:0] rf_writeback_data;
    logic        stall, misaligned;

    mem_writeback_cycle #(.XLEN(32), .REGISTER_SIZE(5)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .in_valid            (in_valid),
        .alu_result          (alu_result),
        .pc_in               (pc_in),
        .dm_read_enable      (dm_read_enable),
        .dm_write_enable     (dm_write_enable),
        .dm_write_data       (dm_write_data),
        .dm_load_type        (dm_load_type),
        .rf_write_enable     (rf_write_enable),
        .rf_write_addr       (rf_write_addr),
        .rf_write_data_sel   (rf_write_data_sel),
        .mem_req             (mem_req),
        .mem_we              (mem_we),
        .mem_addr            (mem_addr),
        .mem_wdata           (mem_wdata),
        .mem_wstrb           (mem_wstrb),
        .mem_ack             (mem_ack),
        .mem_rdata           (mem_rdata),
        .rf_writeback_enable (rf_writeback_enable),
        .rf_writeback_addr   (rf_writeback_addr),
        .rf_writeback_data   (rf_writeback_data),
        .stall               (stall),
        .misaligned          (misaligned)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;
    wb_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every writeback pulse must match the oldest expected entry
    always @(negedge clk) begin
        if (rf_writeback_enable === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL wb_unexpected observed addr=%0d data=%h expected no writeback",
                       rf_writeback_addr, rf_writeback_data);
            end
            if (exp_q.size() != 0) begin
                wb_t e;
                e = exp_q.pop_front();
                check("wb_addr", 32'(rf_writeback_addr), 32'(e.addr));
                check("wb_data", rf_writeback_data, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic idle_in();
        in_valid        = 1'b0;
        dm_read_enable  = 1'b0;
        dm_write_enable = 1'b0;
        rf_write_enable = 1'b0;
        mem_ack         = 1'b0;
    endtask

    task automatic issue(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] wdata,
                         input logic wen, input logic [4:0] rd, input logic [1:0] sel);
        in_valid          = 1'b1;
        dm_read_enable    = rd_en;
        dm_write_enable   = wr_en;
        dm_load_type      = f3;
        alu_result        = alu;
        pc_in             = pc;
        dm_write_data     = wdata;
        rf_write_enable   = wen;
        rf_write_addr     = rd;
        rf_write_data_sel = sel;
        mem_ack           = 1'b0;
    endtask

    // Runs from the cycle after acceptance: gap cycles of request without ack,
    // then the ack cycle, and returns in the cycle after the ack.
    task automatic run_txn(input string tag, input int gap, input logic [31:0] rdata,
                           input logic [31:0] exp_addr, input logic exp_we,
                           input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb);
        for (int i = 0; i < gap; i++) begin
            @(negedge clk); #1;
            check({tag, "_req"},   32'(mem_req), 32'd1);
            check({tag, "_stall"}, 32'(stall), 32'd1);
            check({tag, "_addr"},  mem_addr, exp_addr);
            check({tag, "_we"},    32'(mem_we), 32'(exp_we));
            if (exp_we) begin
                check({tag, "_wdata"}, mem_wdata, exp_wdata);
                check({tag, "_wstrb"}, 32'(mem_wstrb), 32'(exp_wstrb));
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        #1;
        check({tag, "_ack_req"},   32'(mem_req), 32'd1);
        check({tag, "_ack_addr"},  mem_addr, exp_addr);
        check({tag, "_ack_stall"}, 32'(stall), 32'd0);
        @(negedge clk);
        idle_in();
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        check({tag, "_req_drop"}, 32'(mem_req), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        idle_in();
        issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 2'b00);
        in_valid  = 1'b0;
        mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_req",  32'(mem_req), 32'd0);
        check("rst_mem_we",   32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_wdata",    mem_wdata, 32'd0);
        check("rst_wstrb",    32'(mem_wstrb), 32'd0);
        check("rst_wb_en",    32'(rf_writeback_enable), 32'd0);
        check("rst_wb_addr",  32'(rf_writeback_addr), 32'd0);
        check("rst_wb_data",  rf_writeback_data, 32'd0);
        check("rst_mis",      32'(misaligned), 32'd0);
        check("rst_stall",    32'(stall), 32'd0);
        rst = 1'b1;

        // ALU op, latency 1, no stall
        @(negedge clk);
        issue(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 32'h0, 1'b1, 5'd5, 2'b00);
        exp_q.push_back('{addr: 5'd5, data: 32'h1234});
        #1; check("alu_stall", 32'(stall), 32'd0);
        @(negedge clk); idle_in(); #1;
        check("alu_wb_en", 32'(rf_writeback_enable), 32'd1);
        check("alu_stall2", 32'(stall), 32'd0);

        // LB from 0x103, ack three cycles after the request
        @(negedge clk);
        issue(1'b1, 1'b0, F3_LB, 32'h103, 32'h0, 32'h0, 1'b1, 5'd7, 2'b01);
        exp_q.push_back('{addr: 5'd7, data: 32'hFFFF_FF80});
        #1;
        check("lb_accept_stall", 32'(stall), 32'd1);
        check("lb_accept_req",   32'(mem_req), 32'd0);
        run_txn("lb", 3, 32'h8012_3456, 32'h100, 1'b0, 32'h0, 4'h0);
        check("lb_wb_en", 32'(rf_writeback_enable), 32'd1);

        // LBU, same access
        @(negedge clk);
        issue(1'b1, 1'b0, F3_LBU, 32'h103, 32'h0, 32'h0, 1'b1, 5'd7, 2'b01);
        exp_q.push_back('{addr: 5'd7, data: 32'h0000_0080});
        run_txn("lbu", 3, 32'h8012_3456, 32'h100, 1'b0, 32'h0, 4'h0);
        check("lbu_wb_en", 32'(rf_writeback_enable), 32'd1);

        // SH to 0x202; a store never writes back even with rf_write_enable set
        @(negedge clk);
        issue(1'b0, 1'b1, F3_SH, 32'h202, 32'h0, 32'h0000_ABCD, 1'b1, 5'd8, 2'b00);
        run_txn("sh", 2, 32'h0, 32'h200, 1'b1, 32'hABCD_ABCD, 4'b1100);
        check("sh_no_wb", 32'(rf_writeback_enable), 32'd0);

        // SB to 0x501 and SW to 0x600
        @(negedge clk);
        issue(1'b0, 1'b1, F3_SB, 32'h501, 32'h0, 32'h1234_5678, 1'b0, 5'd0, 2'b00);
        run_txn("sb", 1, 32'h0, 32'h500, 1'b1, 32'h7878_7878, 4'b0010);
        @(negedge clk);
        issue(1'b0, 1'b1, F3_SW, 32'h600, 32'h0, 32'hA5A5_0F0F, 1'b0, 5'd0, 2'b00);
        run_txn("sw", 1, 32'h0, 32'h600, 1'b1, 32'hA5A5_0F0F, 4'b1111);

        // Misaligned LW at 0x101: no request, one-cycle flag, no writeback
        @(negedge clk);
        issue(1'b1, 1'b0, F3_LW, 32'h101, 32'h0, 32'h0, 1'b1, 5'd4, 2'b01);
        #1; check("mis_stall", 32'(stall), 32'd0);
        @(negedge clk); idle_in(); #1;
        check("mis_pulse", 32'(misaligned), 32'd1);
        check("mis_req",   32'(mem_req), 32'd0);
        @(negedge clk); #1;
        check("mis_clear", 32'(misaligned), 32'd0);
        check("mis_req2",  32'(mem_req), 32'd0);
        check("mis_no_wb", 32'(rf_writeback_enable), 32'd0);

        // JAL rd=1 with PC+4 wrapping, then JAL rd=0, then sel=11 as ALU
        @(negedge clk);
        issue(1'b0, 1'b0, 3'b000, 32'h12, 32'hFFFF_FFFC, 32'h0, 1'b1, 5'd1, 2'b10);
        exp_q.push_back('{addr: 5'd1, data: 32'h0000_0000});
        @(negedge clk);
        issue(1'b0, 1'b0, 3'b000, 32'h12, 32'h0000_0100, 32'h0, 1'b1, 5'd0, 2'b10);
        #1; check("jal_wb_en", 32'(rf_writeback_enable), 32'd1);
        @(negedge clk);
        issue(1'b0, 1'b0, 3'b000, 32'hCAFE, 32'h40, 32'h0, 1'b1, 5'd6, 2'b11);
        exp_q.push_back('{addr: 5'd6, data: 32'h0000_CAFE});
        #1; check("jal_rd0_no_wb", 32'(rf_writeback_enable), 32'd0);
        @(negedge clk); idle_in(); #1;
        check("sel11_wb_en", 32'(rf_writeback_enable), 32'd1);

        // LH at 0x402 with minimum latency, then an ALU op back-to-back
        @(negedge clk);
        issue(1'b1, 1'b0, F3_LH, 32'h402, 32'h0, 32'h0, 1'b1, 5'd10, 2'b01);
        exp_q.push_back('{addr: 5'd10, data: 32'hFFFF_8001});
        run_txn("lh", 0, 32'h8001_1234, 32'h400, 1'b0, 32'h0, 4'h0);
        check("lh_wb_en", 32'(rf_writeback_enable), 32'd1);
        issue(1'b0, 1'b0, 3'b000, 32'h777, 32'h0, 32'h0, 1'b1, 5'd11, 2'b00);
        exp_q.push_back('{addr: 5'd11, data: 32'h777});
        #1; check("b2b_stall", 32'(stall), 32'd0);
        @(negedge clk); idle_in(); #1;
        check("b2b_wb_en", 32'(rf_writeback_enable), 32'd1);

        // LHU at 0x402
        @(negedge clk);
        issue(1'b1, 1'b0, F3_LHU, 32'h402, 32'h0, 32'h0, 1'b1, 5'd10, 2'b01);
        exp_q.push_back('{addr: 5'd10, data: 32'h0000_8001});
        run_txn("lhu", 1, 32'h8001_1234, 32'h400, 1'b0, 32'h0, 4'h0);

        // Both enables: behaves as a load, no write on the bus
        @(negedge clk);
        issue(1'b1, 1'b1, F3_LW, 32'h500, 32'h0, 32'h9999_9999, 1'b1, 5'd12, 2'b01);
        exp_q.push_back('{addr: 5'd12, data: 32'h0102_0304});
        run_txn("both", 1, 32'h0102_0304, 32'h500, 1'b0, 32'h0, 4'h0);

        // Reset during WAIT: request drops, late ack ignored, no writeback
        @(negedge clk);
        issue(1'b1, 1'b0, F3_LW, 32'h300, 32'h0, 32'h0, 1'b1, 5'd9, 2'b01);
        @(negedge clk);
        rst = 1'b0;
        #1; check("rstw_req_before", 32'(mem_req), 32'd1);
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_5555;
        #1;
        check("rstw_req_drop", 32'(mem_req), 32'd0);
        check("rstw_stall",    32'(stall), 32'd0);
        @(negedge clk); idle_in(); #1;
        check("rstw_no_wb", 32'(rf_writeback_enable), 32'd0);
        check("rstw_req",   32'(mem_req), 32'd0);
        issue(1'b0, 1'b0, 3'b000, 32'h55, 32'h0, 32'h0, 1'b1, 5'd3, 2'b00);
        exp_q.push_back('{addr: 5'd3, data: 32'h55});
        @(negedge clk); idle_in(); #1;
        check("post_rst_wb_en", 32'(rf_writeback_enable), 32'd1);

        repeat (3) @(negedge clk);
        #1;
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
